// File: rtl/counter_sched.sv
// counter_sched: round-robin arbiter lending one shared down-counter
// to NREQ requesters, with a done pulse on completion and abort on withdraw.
module counter_sched #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_len,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      count_out
);

    localparam int IDXW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [IDXW-1:0]   win;
    logic [IDXW-1:0]   last_win;
    logic [IDXW-1:0]   pick;
    logic [WIDTH-1:0]  len_pick;
    logic              found;
    logic              owner_req;

    // Search upward from last_win+1 so the previous owner ranks last.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        len_pick = '0;
        for (int off = 1; off <= NREQ; off++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] &&
                    j == (int'(last_win) + off) % NREQ) begin
                    found    = 1'b1;
                    pick     = IDXW'(j);
                    len_pick = req_len[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign owner_req = req[win];

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (found)
                    state_nx = RUN;
            end
            RUN: begin
                if (!owner_req)
                    state_nx = IDLE;
                else if (count_out == '0)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= '0;
            count_out <= '0;
            win       <= '0;
            last_win  <= IDXW'(NREQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant     <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        count_out <= len_pick;
                        win       <= pick;
                    end
                end
                RUN: begin
                    // Withdrawal ends ownership; count_out keeps its value.
                    if (!owner_req) begin
                        grant    <= '0;
                        last_win <= win;
                    end else if (count_out != '0) begin
                        count_out <= count_out - WIDTH'(1);
                    end
                end
                DONE: begin
                    grant    <= '0;
                    last_win <= win;
                end
                default: ;
            endcase
        end
    end

    assign done = (state == DONE) ? grant : '0;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed scenarios plus random traffic checked
// against a per-transaction timeline model of the scheduler.
module tb_counter_sched;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_len;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   count_out;

    int n_chk = 0;
    int n_err = 0;

    // Model: current owner (-1 idle), cycles since grant, its length.
    int m_owner = -1;
    int m_e     = 0;
    int m_len   = 0;
    int m_last  = N - 1;
    int m_idle_cnt = 0;

    logic           rec = 1'b0;
    logic [N-1:0]   prev_g = '0;
    logic [N-1:0]   order[$];

    counter_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] v;
        v = '0;
        if (m_owner >= 0) v[m_owner] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] exp_done();
        if (m_owner >= 0 && m_e == m_len + 1) return exp_grant();
        return '0;
    endfunction

    function automatic int exp_cnt();
        if (m_owner < 0) return m_idle_cnt;
        return (m_e <= m_len) ? m_len - m_e : 0;
    endfunction

    function automatic logic [N*W-1:0] all_len(input int v);
        logic [N*W-1:0] l;
        for (int i = 0; i < N; i++) l[i*W +: W] = W'(v);
        return l;
    endfunction

    task automatic check_all();
        check("grant", 32'(grant), 32'(exp_grant()));
        check("done", 32'(done), 32'(exp_done()));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("count", 32'(count_out), 32'(exp_cnt()));
    endtask

    task automatic model_step();
        int idx;
        if (m_owner < 0) begin
            for (int off = 1; off <= N; off++) begin
                idx = (m_last + off) % N;
                if (req[idx]) begin
                    m_owner = idx;
                    m_len   = int'(req_len[idx*W +: W]);
                    m_e     = 0;
                    break;
                end
            end
        end else if (m_e <= m_len) begin
            if (!req[m_owner]) begin
                m_idle_cnt = m_len - m_e;
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_e++;
            end
        end else begin
            m_idle_cnt = 0;
            m_last  = m_owner;
            m_owner = -1;
        end
    endtask

    // Entered and left at a falling edge.
    task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] l);
        check_all();
        req     = r;
        req_len = l;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        check_all();
        #2 rst = 1'b1;
        #1;
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_count", 32'(count_out), 32'(0));
        m_owner = -1;
        m_last  = N - 1;
        m_idle_cnt = 0;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rec && grant != '0 && grant != prev_g) order.push_back(grant);
        prev_g = grant;
    end

    initial begin
        logic [N*W-1:0] l;
        logic [N-1:0]   r;
        logic [N-1:0]   ed;
        logic [N-1:0]   ord_exp[5];
        logic [N-1:0]   got;

        rst = 1'b1;
        req = '0;
        req_len = '0;
        @(negedge clk);
        check_all();
        rst = 1'b0;

        rec = 1'b1;
        repeat (22) cycle(4'b1111, all_len(1));
        rec = 1'b0;
        ord_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            got = (i < order.size()) ? order[i] : '0;
            check($sformatf("order%0d", i), 32'(got), 32'(ord_exp[i]));
        end
        repeat (3) cycle('0, '0);

        l = '0;
        l[2*W +: W] = 4'd3;
        repeat (6) cycle(4'b0100, l);
        repeat (3) cycle('0, l);

        repeat (4) cycle(4'b0001, '0);
        repeat (2) cycle('0, '0);

        l = '0;
        l[1*W +: W] = 4'd15;
        repeat (19) cycle(4'b0010, l);
        repeat (3) cycle('0, l);

        l = '0;
        l[1*W +: W] = 4'd10;
        repeat (4) cycle(4'b0010, l);
        repeat (4) cycle(4'b0100, all_len(2));
        repeat (4) cycle('0, '0);

        l = '0;
        l[0 +: W] = 4'd9;
        for (int n = 0; n < 20 && !(m_owner >= 0 && exp_cnt() == 5); n++)
            cycle(4'b0001, l);
        check("pre_rst_count", 32'(count_out), 32'(5));
        do_reset();
        repeat (5) cycle(4'b1000, all_len(2));
        repeat (2) cycle('0, '0);

        r = '0;
        repeat (3000) begin
            if ($urandom % 300 == 0) begin
                do_reset();
                r = '0;
            end else begin
                ed = exp_done();
                for (int i = 0; i < N; i++) begin
                    if (r[i]) begin
                        if (ed[i] && ($urandom % 2 == 0)) r[i] = 1'b0;
                        else if ($urandom % 24 == 0) r[i] = 1'b0;
                    end else if ($urandom % 4 == 0) begin
                        r[i] = 1'b1;
                    end
                    case ($urandom % 6)
                        0:       l[i*W +: W] = '0;
                        1:       l[i*W +: W] = '1;
                        default: l[i*W +: W] = W'($urandom % 16);
                    endcase
                end
                cycle(r, l);
            end
        end
        repeat (20) cycle('0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
